// File: rtl/xdcr_out_sequencer.sv
// Output gating between the pwm block and XDCR_OUT: ramps transducer groups on one
// step interval at a time and forces all outputs low on fault or disable.
module xdcr_out_sequencer #(
    parameter int unsigned TRANS_NUM  = 249,
    parameter int unsigned GROUP_SIZE = 32,
    parameter int unsigned STEP_TICKS = 20480,
    localparam int unsigned NUM_GROUPS = (TRANS_NUM + GROUP_SIZE - 1) / GROUP_SIZE,
    localparam int unsigned AGW        = $clog2(NUM_GROUPS + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ENABLE,
    input  logic                 FAULT,
    input  logic [TRANS_NUM-1:0] PWM_IN,
    output logic [TRANS_NUM-1:0] PWM_OUT,
    output logic [1:0]           STATE,
    output logic [AGW-1:0]       ACTIVE_GROUPS,
    output logic                 READY
);

    localparam int unsigned      CW       = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(STEP_TICKS - 1);
    localparam logic [AGW-1:0]   NG_W     = AGW'(NUM_GROUPS);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RAMP = 2'd1,
        S_RUN  = 2'd2,
        S_FLT  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [AGW-1:0] ag_q, ag_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TRANS_NUM-1:0] grp_mask;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_OFF;
            ag_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ag_q    <= ag_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ag_d    = ag_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_OFF: begin
                if (FAULT) begin
                    state_d = S_FLT;
                end else if (ENABLE) begin
                    state_d = S_RAMP;
                    ag_d    = AGW'(1);
                    cnt_d   = '0;
                end
            end
            S_RAMP: begin
                if (FAULT) begin
                    state_d = S_FLT;
                    ag_d    = '0;
                    cnt_d   = '0;
                end else if (!ENABLE) begin
                    state_d = S_OFF;
                    ag_d    = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (ag_q == NG_W) state_d = S_RUN;
                    else              ag_d    = ag_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (FAULT) begin
                    state_d = S_FLT;
                    ag_d    = '0;
                end else if (!ENABLE) begin
                    state_d = S_OFF;
                    ag_d    = '0;
                end
            end
            S_FLT: begin
                // Re-arming needs ENABLE low as well, so a held enable cannot restart a ramp.
                ag_d = '0;
                if (!FAULT && !ENABLE) state_d = S_OFF;
            end
            default: begin
                state_d = S_OFF;
                ag_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Group index per output is an elaboration-time constant, so only comparators remain.
    for (genvar i = 0; i < TRANS_NUM; i++) begin : g_mask
        localparam logic [AGW-1:0] GRP = AGW'(i / GROUP_SIZE);
        assign grp_mask[i] = (GRP < ag_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) PWM_OUT <= '0;
        else     PWM_OUT <= PWM_IN & grp_mask & {TRANS_NUM{ENABLE & ~FAULT}};
    end

    assign STATE         = state_q;
    assign ACTIVE_GROUPS = ag_q;
    assign READY         = (state_q == S_RUN);

endmodule

// File: tb/tb_xdcr_out_sequencer.sv
// Bench for xdcr_out_sequencer: time-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized enable/fault/pwm traffic.
module tb_xdcr_out_sequencer;

    localparam int TN = 249;
    localparam int GS = 32;
    localparam int ST = 4;
    localparam int NG = (TN + GS - 1) / GS;
    localparam int M_OFF = 0, M_RAMP = 1, M_RUN = 2, M_FLT = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ENABLE;
    logic          FAULT;
    logic [TN-1:0] PWM_IN;
    logic [TN-1:0] PWM_OUT;
    logic [1:0]    STATE;
    logic [3:0]    ACTIVE_GROUPS;
    logic          READY;

    xdcr_out_sequencer #(
        .TRANS_NUM (TN),
        .GROUP_SIZE(GS),
        .STEP_TICKS(ST)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ENABLE       (ENABLE),
        .FAULT        (FAULT),
        .PWM_IN       (PWM_IN),
        .PWM_OUT      (PWM_OUT),
        .STATE        (STATE),
        .ACTIVE_GROUPS(ACTIVE_GROUPS),
        .READY        (READY)
    );

    always #5 CLK = ~CLK;

    // Reference model: ramp progress derived from edges elapsed since ramp entry.
    int            m_state;
    int            m_ag;
    int            old_ag;
    int            cyc;
    int            m_start;
    logic [TN-1:0] m_pwm;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_state = M_OFF;
            m_ag    = 0;
            m_pwm   = '0;
            cyc     = 0;
            m_start = 0;
        end else begin
            old_ag = m_ag;
            cyc    = cyc + 1;
            for (int i = 0; i < TN; i++)
                m_pwm[i] = PWM_IN[i] & ~FAULT & ENABLE & ((i / GS) < old_ag);
            if (m_state == M_FLT) begin
                if (!FAULT && !ENABLE) m_state = M_OFF;
            end else if (FAULT) begin
                m_state = M_FLT;
            end else if (!ENABLE) begin
                m_state = M_OFF;
            end else if (m_state == M_OFF) begin
                m_state = M_RAMP;
                m_start = cyc;
            end else if (m_state == M_RAMP && (cyc - m_start) >= NG * ST) begin
                m_state = M_RUN;
            end
            if (m_state == M_RAMP)     m_ag = 1 + (cyc - m_start) / ST;
            else if (m_state == M_RUN) m_ag = NG;
            else                       m_ag = 0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp();
        chk("model_state", 256'(STATE), 256'(m_state));
        chk("model_ag", 256'(ACTIVE_GROUPS), 256'(m_ag));
        chk("model_ready", 256'(READY), 256'(m_state == M_RUN));
        chk("model_pwm", 256'(PWM_OUT), 256'(m_pwm));
    endtask

    task automatic step();
        @(negedge CLK);
        cmp();
    endtask

    function automatic logic [TN-1:0] rand_vec();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v[TN-1:0];
    endfunction

    logic [TN-1:0] prev_in;
    logic [TN-1:0] lo_mask;

    initial begin
        RST = 1'b1; ENABLE = 1'b0; FAULT = 1'b0; PWM_IN = '0;
        lo_mask = '0;
        lo_mask[31:0] = '1;
        repeat (2) step();
        chk("rst_state", 256'(STATE), 256'(0));
        chk("rst_ag", 256'(ACTIVE_GROUPS), 256'(0));
        chk("rst_ready", 256'(READY), 256'(0));
        chk("rst_pwm", 256'(PWM_OUT), 256'(0));
        RST = 1'b0;
        step();

        // Full ramp with all inputs high; edge n after enable is ramp cycle n-1.
        PWM_IN = '1;
        ENABLE = 1'b1;
        for (int n = 1; n <= 34; n++) begin
            step();
            if (n == 1) begin
                chk("ramp_entry_state", 256'(STATE), 256'(1));
                chk("ramp_entry_ag", 256'(ACTIVE_GROUPS), 256'(1));
                chk("ramp_entry_pwm", 256'(PWM_OUT), 256'(0));
            end
            if (n == 2)  chk("grp0_on", 256'(PWM_OUT), 256'(lo_mask));
            if (n == 5)  chk("ag_2", 256'(ACTIVE_GROUPS), 256'(2));
            if (n == 29) begin
                chk("ag_8", 256'(ACTIVE_GROUPS), 256'(8));
                chk("grp7_off_c28", 256'(PWM_OUT[248:224]), 256'(0));
            end
            if (n == 30) chk("grp7_on_c29", 256'(PWM_OUT[248:224]), 256'(25'h1ffffff));
            if (n == 32) chk("still_ramp_c31", 256'(STATE), 256'(1));
            if (n == 33) begin
                chk("run_c32", 256'(STATE), 256'(2));
                chk("ready_c32", 256'(READY), 256'(1));
            end
        end

        // Random PWM_IN in RUN: one-cycle delayed pass-through.
        for (int n = 0; n < 40; n++) begin
            PWM_IN  = rand_vec();
            prev_in = PWM_IN;
            step();
            chk("run_passthru", 256'(PWM_OUT), 256'(prev_in));
            chk("run_partial_grp", 256'(PWM_OUT[248:224]), 256'(prev_in[248:224]));
        end

        // One-cycle fault in RUN with enable held.
        PWM_IN = '1;
        FAULT  = 1'b1;
        step();
        chk("fault_state", 256'(STATE), 256'(3));
        chk("fault_pwm", 256'(PWM_OUT), 256'(0));
        FAULT = 1'b0;
        repeat (3) step();
        chk("flt_held", 256'(STATE), 256'(3));
        chk("flt_held_ag", 256'(ACTIVE_GROUPS), 256'(0));
        ENABLE = 1'b0;
        step();
        chk("flt_exit", 256'(STATE), 256'(0));
        ENABLE = 1'b1;
        step();
        chk("rearm_state", 256'(STATE), 256'(1));
        chk("rearm_ag", 256'(ACTIVE_GROUPS), 256'(1));

        // Disable mid-ramp at three active groups.
        repeat (8) step();
        chk("mid_ag3", 256'(ACTIVE_GROUPS), 256'(3));
        ENABLE = 1'b0;
        step();
        chk("dis_state", 256'(STATE), 256'(0));
        chk("dis_ag", 256'(ACTIVE_GROUPS), 256'(0));
        chk("dis_pwm", 256'(PWM_OUT), 256'(0));

        // Fault and enable rising together in OFF.
        FAULT = 1'b1; ENABLE = 1'b1;
        step();
        chk("fe_state", 256'(STATE), 256'(3));
        chk("fe_pwm", 256'(PWM_OUT), 256'(0));
        FAULT = 1'b0; ENABLE = 1'b0;
        step();
        chk("fe_exit", 256'(STATE), 256'(0));

        // Asynchronous reset mid-ramp, released with enable held.
        ENABLE = 1'b1;
        repeat (6) step();
        chk("pre_rst_ag", 256'(ACTIVE_GROUPS), 256'(2));
        #2 RST = 1'b1;
        #1;
        chk("arst_pwm", 256'(PWM_OUT), 256'(0));
        chk("arst_state", 256'(STATE), 256'(0));
        chk("arst_ag", 256'(ACTIVE_GROUPS), 256'(0));
        chk("arst_ready", 256'(READY), 256'(0));
        repeat (2) step();
        #2 RST = 1'b0;
        step();
        chk("post_rst_state", 256'(STATE), 256'(1));
        chk("post_rst_ag", 256'(ACTIVE_GROUPS), 256'(1));

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            PWM_IN = rand_vec();
            if ($urandom_range(0, 63) == 0) ENABLE = ~ENABLE;
            if ($urandom_range(0, 99) < 2)  FAULT  = ~FAULT;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
